morse_pattern_tx: RTL and testbench



---
 rtl/morse_pattern_tx_if.sv | 26 ++
 rtl/morse_pattern_tx.sv | 114 +++++++++++
 tb/tb_morse_pattern_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/morse_pattern_tx_if.sv
// Handshake and serial-output bundle for the Morse light-pattern transmitter.
// The master supplies the pattern request; the slave is the transmitter itself.
interface morse_pattern_tx_if #(
    parameter int PAT_W = 16,
    parameter int LEN_W = $clog2(PAT_W + 1)
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic             repeat_en;
    logic             abort;
    logic             busy;
    logic             done;
    logic             tick;
    logic             light;

    modport master (
        output start, pattern, length, repeat_en, abort,
        input  busy, done, tick, light
    );

    modport slave (
        input  start, pattern, length, repeat_en, abort,
        output busy, done, tick, light
    );
endinterface

// File: rtl/morse_pattern_tx.sv
// Serial light-pattern transmitter: shifts a variable-length pattern out LSB first,
// one bit per DIV-clock symbol period, with optional gapped auto-repeat and abort.
module morse_pattern_tx #(
    parameter int PAT_W     = 16,
    parameter int DIV       = 25000000,
    parameter int GAP_TICKS = 3
) (
    input  logic               clk,
    input  logic               resetn,
    morse_pattern_tx_if.slave  bus
);
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] shreg;
    logic [PAT_W-1:0] shadow;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] len_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             busy_q;
    logic             done_q;
    logic             light_q;

    logic             div_end;
    logic             tick_w;
    logic [LEN_W-1:0] len_eff;
    logic [PAT_W-1:0] shreg_nxt;

    // tick is decoded from the divider so the shift happens on the same edge it marks
    assign div_end   = (div_cnt == DIV_W'(DIV - 1));
    assign tick_w    = (state != IDLE) && div_end;
    assign len_eff   = (bus.length > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.length;
    assign shreg_nxt = shreg >> 1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the pattern storage is cleared too; it is a handful of flops,
            // not a RAM, so resetting it costs nothing and keeps state deterministic.
            state   <= IDLE;
            shreg   <= '0;
            shadow  <= '0;
            bit_cnt <= '0;
            len_q   <= '0;
            gap_cnt <= '0;
            div_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            light_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                div_cnt <= '0;
                if (bus.start && (bus.length != '0) && !bus.abort) begin
                    shreg   <= bus.pattern;
                    shadow  <= bus.pattern;
                    bit_cnt <= len_eff;
                    len_q   <= len_eff;
                    light_q <= bus.pattern[0];
                    busy_q  <= 1'b1;
                    state   <= SEND;
                end
            end else if (bus.abort) begin
                state   <= IDLE;
                div_cnt <= '0;
                busy_q  <= 1'b0;
                light_q <= 1'b0;
            end else begin
                div_cnt <= div_end ? '0 : div_cnt + DIV_W'(1);
                if (div_end) begin
                    if (state == SEND) begin
                        shreg   <= shreg_nxt;
                        bit_cnt <= bit_cnt - LEN_W'(1);
                        light_q <= shreg_nxt[0];
                        if (bit_cnt == LEN_W'(1)) begin
                            light_q <= 1'b0;
                            if (bus.repeat_en) begin
                                gap_cnt <= GAP_W'(GAP_TICKS);
                                state   <= GAP;
                            end else begin
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                        if (gap_cnt == GAP_W'(1)) begin
                            shreg   <= shadow;
                            bit_cnt <= len_q;
                            light_q <= shadow[0];
                            state   <= SEND;
                        end
                    end
                end
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tick  = tick_w;
    assign bus.light = light_q;
endmodule

// File: tb/tb_morse_pattern_tx.sv
// Directed bench for morse_pattern_tx: one instance at DIV=4/GAP_TICKS=2, one at DIV=1.
// Outputs are sampled 1 ns after each rising edge.
module tb_morse_pattern_tx;
    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    morse_pattern_tx_if #(.PAT_W(8)) bus0 ();
    morse_pattern_tx_if #(.PAT_W(8)) bus1 ();

    morse_pattern_tx #(.PAT_W(8), .DIV(4), .GAP_TICKS(2)) u_dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    morse_pattern_tx #(.PAT_W(8), .DIV(1), .GAP_TICKS(2)) u_dut1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] pat, input logic [3:0] len);
        bus0.pattern = pat;
        bus0.length  = len;
        bus0.start   = 1'b1;
        step();
        bus0.start   = 1'b0;
    endtask

    // One pass on DUT0 (DIV=4): bit k/4 of pat is on light during cycle k.
    task automatic expect_pass(input logic [7:0] pat, input int nbits, input int drop_at,
                               input string tag);
        int ticks;
        ticks = 0;
        for (int k = 0; k < nbits * 4; k++) begin
            if (k == drop_at) bus0.repeat_en = 1'b0;
            check({tag, " light"}, bus0.light, pat[k/4]);
            check({tag, " busy"},  bus0.busy, 1);
            check({tag, " done"},  bus0.done, 0);
            check({tag, " tick"},  bus0.tick, (k % 4) == 3);
            if (bus0.tick) ticks++;
            step();
        end
        check({tag, " tick count"}, ticks, nbits);
    endtask

    task automatic expect_end(input string tag);
        check({tag, " end done"},  bus0.done, 1);
        check({tag, " end busy"},  bus0.busy, 0);
        check({tag, " end light"}, bus0.light, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp6;

        resetn         = 1'b0;
        bus0.start     = 1'b0;
        bus0.pattern   = '0;
        bus0.length    = '0;
        bus0.repeat_en = 1'b0;
        bus0.abort     = 1'b0;
        bus1.start     = 1'b0;
        bus1.pattern   = '0;
        bus1.length    = '0;
        bus1.repeat_en = 1'b0;
        bus1.abort     = 1'b0;

        #1;
        check("reset busy",  bus0.busy, 0);
        check("reset done",  bus0.done, 0);
        check("reset tick",  bus0.tick, 0);
        check("reset light", bus0.light, 0);
        step();
        step();
        resetn = 1'b1;
        step();
        check("idle busy", bus0.busy, 0);

        // 1: basic 5-bit pass
        start_tx(8'b00010101, 4'd5);
        expect_pass(8'b00010101, 5, -1, "t1");
        expect_end("t1");
        step();
        check("t1 done one cycle", bus0.done, 0);

        // 2: auto-repeat with gap, repeat dropped during second pass
        bus0.repeat_en = 1'b1;
        start_tx(8'b00000111, 4'd3);
        expect_pass(8'b00000111, 3, -1, "t2 pass1");
        for (int k = 0; k < 8; k++) begin
            check("t2 gap light", bus0.light, 0);
            check("t2 gap busy",  bus0.busy, 1);
            check("t2 gap done",  bus0.done, 0);
            step();
        end
        expect_pass(8'b00000111, 3, 5, "t2 pass2");
        expect_end("t2");
        for (int k = 0; k < 12; k++) begin
            step();
            check("t2 after light", bus0.light, 0);
            check("t2 after busy",  bus0.busy, 0);
            check("t2 after done",  bus0.done, 0);
        end

        // 3: abort during bit 2, then a fresh start
        start_tx(8'b00010101, 4'd5);
        for (int k = 0; k < 6; k++) begin
            check("t3 pre-abort light", bus0.light, (k < 4) ? 1 : 0);
            if (k == 5) bus0.abort = 1'b1;
            step();
        end
        bus0.abort = 1'b0;
        check("t3 abort light", bus0.light, 0);
        check("t3 abort busy",  bus0.busy, 0);
        check("t3 abort done",  bus0.done, 0);
        check("t3 abort tick",  bus0.tick, 0);
        start_tx(8'b00001101, 4'd4);
        expect_pass(8'b00001101, 4, -1, "t3 restart");
        expect_end("t3");

        // 4: start while busy ignored; done+start accepted; length 0; length clamp
        bus0.pattern = 8'b00010101;
        bus0.length  = 4'd5;
        bus0.start   = 1'b1;
        step();
        bus0.pattern = 8'hFF;
        bus0.length  = 4'd8;
        expect_pass(8'b00010101, 5, -1, "t4 busy start");
        expect_end("t4");
        bus0.pattern = 8'b00000011;
        bus0.length  = 4'd2;
        step();
        bus0.start = 1'b0;
        expect_pass(8'b00000011, 2, -1, "t4 done+start");
        expect_end("t4b");
        step();
        bus0.pattern = 8'hFF;
        bus0.length  = 4'd0;
        bus0.start   = 1'b1;
        step();
        bus0.start = 1'b0;
        check("t4 len0 busy",  bus0.busy, 0);
        check("t4 len0 light", bus0.light, 0);
        step();
        check("t4 len0 busy later", bus0.busy, 0);
        start_tx(8'hFF, 4'd12);
        expect_pass(8'hFF, 8, -1, "t4 clamp");
        expect_end("t4 clamp");
        step();

        // 5: asynchronous reset mid-bit
        start_tx(8'b00010101, 4'd5);
        step();
        step();
        step();
        check("t5 pre light", bus0.light, 1);
        check("t5 pre tick",  bus0.tick, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("t5 rst light", bus0.light, 0);
        check("t5 rst busy",  bus0.busy, 0);
        check("t5 rst done",  bus0.done, 0);
        check("t5 rst tick",  bus0.tick, 0);
        step();
        resetn = 1'b1;
        step();
        check("t5 idle busy", bus0.busy, 0);
        check("t5 idle done", bus0.done, 0);
        start_tx(8'b00000110, 4'd3);
        expect_pass(8'b00000110, 3, -1, "t5 restart");
        expect_end("t5");

        // 6: DIV=1 instance, one bit per cycle
        exp6         = 8'b10110010;
        bus1.pattern = 8'b10110010;
        bus1.length  = 4'd8;
        bus1.start   = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t6 light", bus1.light, exp6[k]);
            check("t6 tick",  bus1.tick, 1);
            check("t6 busy",  bus1.busy, 1);
            check("t6 done",  bus1.done, 0);
            step();
        end
        check("t6 end done",  bus1.done, 1);
        check("t6 end busy",  bus1.busy, 0);
        check("t6 end light", bus1.light, 0);
        step();
        check("t6 done one cycle", bus1.done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
